// File: rtl/decoder_fixed_point_seq_if.sv
// ----------------------------------------------------------------------------
// decoder_fixed_point_seq_if
//   Groups the request/response signals of decoder_fixed_point_seq.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. A source holds valid and its data stable until
//   that edge. A sink may drive ready independently of valid.
//
//   Signals:
//     in_valid / in_ready   request handshake for latent vector z
//     z                     N_input words, element i at z[i*BITSIZE +: BITSIZE]
//     w                     N_input*M_output weights, k=j*N_input+i
//     b                     M_output biases
//     out_valid / out_ready result handshake
//     out                   M_output result words, same packing as b
//     busy                  a computation is in progress
//     state_dbg             current FSM state (IDLE=0, MAC=1, DONE=2)
//
//   Modports: master = producer/consumer side (the bench), slave = the decoder.
// ----------------------------------------------------------------------------
interface decoder_fixed_point_seq_if #(
   parameter int N_input  = 2,
   parameter int M_output = 9,
   parameter int BITSIZE  = 32
);
   logic                            in_valid;
   logic                            in_ready;
   logic [N_input*BITSIZE-1:0]      z;
   logic [N_input*M_output*BITSIZE-1:0] w;
   logic [M_output*BITSIZE-1:0]     b;
   logic                            out_valid;
   logic                            out_ready;
   logic [M_output*BITSIZE-1:0]     out;
   logic                            busy;
   logic [1:0]                      state_dbg;

   modport master (
      output in_valid, z, w, b, out_ready,
      input  in_ready, out_valid, out, busy, state_dbg
   );

   modport slave (
      input  in_valid, z, w, b, out_ready,
      output in_ready, out_valid, out, busy, state_dbg
   );
endinterface

// File: rtl/decoder_fixed_point_seq.sv
// ----------------------------------------------------------------------------
// decoder_fixed_point_seq
//   Sequential fixed-point dense decoder layer:
//     out[j] = sat(sum_i z[i]*w[j*N_input+i] + b[j])
//   One shared multiplier produces one product per cycle, so a full vector
//   takes N_input*M_output cycles after the accept edge.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    decoder_fixed_point_seq_if.slave (handshakes, z/w/b, out, busy)
//
//   Build option:
//     DECODER_RELU_EN  when defined, negative saturated results are written
//                      as zero. Timing is identical either way.
// ----------------------------------------------------------------------------
module decoder_fixed_point_seq #(
   parameter int N_input  = 2,
   parameter int M_output = 9,
   parameter int BITSIZE  = 32,
   parameter int FRAC     = 26,
   parameter int GUARD    = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   decoder_fixed_point_seq_if.slave bus
);
   localparam int ACCW = BITSIZE + GUARD;
   localparam int PW   = 2 * BITSIZE;
   localparam int IW   = (N_input  > 1) ? $clog2(N_input)  : 1;
   localparam int JW   = (M_output > 1) ? $clog2(M_output) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N_input - 1);
   localparam logic [JW-1:0] J_LAST = JW'(M_output - 1);

   // Saturation bounds expressed at accumulator width.
   localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'({1'b0, {(BITSIZE-1){1'b1}}});
   localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                      state;
   logic [BITSIZE-1:0]          zreg [N_input];
   logic [IW-1:0]               i_cnt;
   logic [JW-1:0]               j_cnt;
   logic signed [ACCW-1:0]      acc;
   logic [M_output*BITSIZE-1:0] out_r;
   logic                        out_valid_r;
   logic                        busy_r;
   logic                        in_ready_r;

   // ---------------- MAC datapath ----------------
   logic signed [BITSIZE-1:0] z_sel;
   logic signed [BITSIZE-1:0] w_sel;
   logic signed [BITSIZE-1:0] b_sel;
   logic signed [PW-1:0]      prod;
   logic signed [PW-1:0]      prod_sh;
   logic signed [ACCW-1:0]    term;
   logic signed [ACCW-1:0]    acc_base;
   logic signed [ACCW-1:0]    acc_next;
   logic [BITSIZE-1:0]        sat_val;
   logic [BITSIZE-1:0]        wr_val;

   always_comb begin
      z_sel    = zreg[i_cnt];
      w_sel    = bus.w[(int'(j_cnt) * N_input + int'(i_cnt)) * BITSIZE +: BITSIZE];
      b_sel    = bus.b[int'(j_cnt) * BITSIZE +: BITSIZE];
      prod     = z_sel * w_sel;
      // Arithmetic shift floors toward -inf (e.g. -2^-26 stays -2^-26 LSB).
      prod_sh  = prod >>> FRAC;
      term     = ACCW'(prod_sh);
      // First product of a row starts from the sign-extended bias.
      acc_base = (i_cnt == '0) ? ACCW'(b_sel) : acc;
      acc_next = acc_base + term;

      if (acc_next > SAT_MAX) begin
         sat_val = {1'b0, {(BITSIZE-1){1'b1}}};
      end else if (acc_next < SAT_MIN) begin
         sat_val = {1'b1, {(BITSIZE-1){1'b0}}};
      end else begin
         sat_val = acc_next[BITSIZE-1:0];
      end

`ifdef DECODER_RELU_EN
      wr_val = sat_val[BITSIZE-1] ? '0 : sat_val;
`else
      wr_val = sat_val;
`endif
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         i_cnt       <= '0;
         j_cnt       <= '0;
         acc         <= '0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         for (int n = 0; n < N_input; n++) begin
            zreg[n] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  for (int n = 0; n < N_input; n++) begin
                     zreg[n] <= bus.z[n*BITSIZE +: BITSIZE];
                  end
                  i_cnt      <= '0;
                  j_cnt      <= '0;
                  busy_r     <= 1'b1;
                  in_ready_r <= 1'b0;
                  state      <= MAC;
               end
            end
            MAC: begin
               acc <= acc_next;
               if (i_cnt == I_LAST) begin
                  out_r[int'(j_cnt)*BITSIZE +: BITSIZE] <= wr_val;
                  i_cnt <= '0;
                  if (j_cnt == J_LAST) begin
                     j_cnt       <= '0;
                     busy_r      <= 1'b0;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     j_cnt <= j_cnt + 1'b1;
                  end
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out       = out_r;
   assign bus.busy      = busy_r;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_decoder_fixed_point_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_fixed_point_seq
//   Self-checking bench for decoder_fixed_point_seq. The reference model
//   computes each output from plain 64-bit integer arithmetic (floor division
//   by 2^FRAC, clamp to the word range). Inputs are driven and outputs sampled
//   1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_decoder_fixed_point_seq;
   localparam int N     = 2;
   localparam int M     = 9;
   localparam int BW    = 32;
   localparam int FRAC  = 26;
   localparam int GUARD = 8;
   localparam int OUT_W = M * BW;
   localparam int LAT   = N * M;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decoder_fixed_point_seq_if #(.N_input(N), .M_output(M), .BITSIZE(BW)) bus ();

   decoder_fixed_point_seq #(
      .N_input(N), .M_output(M), .BITSIZE(BW), .FRAC(FRAC), .GUARD(GUARD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [OUT_W-1:0] exp_q[$];

   logic signed [BW-1:0] tz  [N];
   logic signed [BW-1:0] tw  [N*M];
   logic signed [BW-1:0] tbv [M];

   task automatic check(input string tag, input logic [OUT_W-1:0] got,
                        input logic [OUT_W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: exact products, floor to the FRAC grid, sum, clamp.
   function automatic logic [OUT_W-1:0] model();
      logic [OUT_W-1:0] r;
      longint s, p, q;
      longint one;
      longint hi, lo;
      one = 64'sd1 <<< FRAC;
      hi  = (64'sd1 <<< (BW-1)) - 1;
      lo  = -(64'sd1 <<< (BW-1));
      r   = '0;
      for (int j = 0; j < M; j++) begin
         s = longint'(tbv[j]);
         for (int i = 0; i < N; i++) begin
            p = longint'(tz[i]) * longint'(tw[j*N+i]);
            q = p / one;
            if (p < 0 && (p % one) != 0) q = q - 1;
            s = s + q;
         end
         if (s > hi) s = hi;
         else if (s < lo) s = lo;
`ifdef DECODER_RELU_EN
         if (s < 0) s = 0;
`endif
         r[j*BW +: BW] = s[BW-1:0];
      end
      return r;
   endfunction

   function automatic logic signed [BW-1:0] rnd_word(input int mode);
      if (mode == 0) return $urandom();
      // Roughly [-8.0, 8.0) so sums mostly stay in range.
      return $urandom_range(0, 32'h3FFF_FFFF) - 32'h2000_0000;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic pack();
      for (int i = 0; i < N; i++)   bus.z[i*BW +: BW] = tz[i];
      for (int k = 0; k < N*M; k++) bus.w[k*BW +: BW] = tw[k];
      for (int j = 0; j < M; j++)   bus.b[j*BW +: BW] = tbv[j];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns just after the accept edge.
   task automatic send();
      int n;
      pack();
      exp_q.push_back(model());
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      check("accept_ready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Waits for out_valid counting edges since accept, then checks result.
   task automatic wait_result(input string tag);
      int n;
      logic [OUT_W-1:0] e;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, n, LAT);
      check({tag, "_busy_done"}, bus.busy, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, "_out"}, bus.out, e);
   endtask

   task automatic release_out(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({tag, "_ovalid_clr"}, bus.out_valid, 1'b0);
      check({tag, "_iready_back"}, bus.in_ready, 1'b1);
   endtask

   task automatic set_all(input logic signed [BW-1:0] zv0, input logic signed [BW-1:0] zv1,
                          input logic signed [BW-1:0] wv, input logic signed [BW-1:0] bv);
      tz[0] = zv0;
      tz[1] = zv1;
      for (int k = 0; k < N*M; k++) tw[k] = wv;
      for (int j = 0; j < M; j++)   tbv[j] = bv;
   endtask

   task automatic set_random(input int mode);
      for (int i = 0; i < N; i++)   tz[i]  = rnd_word(mode);
      for (int k = 0; k < N*M; k++) tw[k]  = rnd_word(mode);
      for (int j = 0; j < M; j++)   tbv[j] = rnd_word(mode);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [OUT_W-1:0] held;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.z = '0;
      bus.w = '0;
      bus.b = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out", bus.out, '0);
      rst_n = 1'b1;
      tick();

      // Basic: 1.0*1.0 + 2.0*1.0 + 0.5 = 3.5
      set_all(32'h0400_0000, 32'h0800_0000, 32'h0400_0000, 32'h0200_0000);
      send();
      check("basic_busy", bus.busy, 1'b1);
      wait_result("basic");
      check("basic_elem0", bus.out[BW-1:0], 32'h0E00_0000);
      check("basic_elem8", bus.out[8*BW +: BW], 32'h0E00_0000);
      release_out("basic");

      // Sign/truncation: -1.0 * 2^-26 floors to -1 LSB.
      set_random(1);
      tz[0] = 32'hFC00_0000;
      tz[1] = '0;
      tw[0] = 32'h0000_0001;
      for (int j = 0; j < M; j++) tbv[j] = '0;
      send();
      wait_result("trunc");
      check("trunc_elem0", bus.out[BW-1:0], 32'hFFFF_FFFF);
      release_out("trunc");

      // Saturation both directions.
      set_all(32'h7C00_0000, 32'h7C00_0000, 32'h7C00_0000, '0);
      send();
      wait_result("sat_pos");
`ifdef DECODER_RELU_EN
      check("sat_pos_all", bus.out, {M{32'h7FFF_FFFF}});
      release_out("sat_pos");
      set_all(32'h7C00_0000, 32'h7C00_0000, 32'h8400_0000, '0);
      send();
      wait_result("sat_neg");
      check("sat_neg_all", bus.out, '0);
`else
      check("sat_pos_all", bus.out, {M{32'h7FFF_FFFF}});
      release_out("sat_pos");
      set_all(32'h7C00_0000, 32'h7C00_0000, 32'h8400_0000, '0);
      send();
      wait_result("sat_neg");
      check("sat_neg_all", bus.out, {M{32'h8000_0000}});
`endif
      release_out("sat_neg");

      // Random vectors, mixing full-range and moderate magnitudes.
      for (int t = 0; t < 8; t++) begin
         set_random(t % 3 == 0 ? 0 : 1);
         send();
         wait_result("rand");
         release_out("rand");
      end

      // Backpressure with a second request waiting.
      set_random(1);
      send();
      wait_result("bp_first");
      held = bus.out;
      set_random(1);
      pack();
      exp_q.push_back(model());
      bus.in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("bp_out_stable", bus.out, held);
         check("bp_in_ready", bus.in_ready, 1'b0);
         check("bp_out_valid", bus.out_valid, 1'b1);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("bp_release_ovalid", bus.out_valid, 1'b0);
      check("bp_release_iready", bus.in_ready, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_second_busy", bus.busy, 1'b1);
      check("bp_second_iready", bus.in_ready, 1'b0);
      wait_result("bp_second");
      release_out("bp_second");

      // Reset in the middle of MAC.
      set_random(1);
      send();
      repeat (6) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      check("mid_rst_out_valid", bus.out_valid, 1'b0);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_in_ready", bus.in_ready, 1'b1);
      check("mid_rst_out", bus.out, '0);
      set_random(1);
      send();
      wait_result("after_rst");
      release_out("after_rst");

      // Negative bias: 3.0 + (-8.0) = -5.0 (0xEC000000), clamped to 0 with ReLU.
      set_all(32'h0400_0000, 32'h0800_0000, 32'h0400_0000, 32'hE000_0000);
      send();
      wait_result("relu");
`ifdef DECODER_RELU_EN
      check("relu_all", bus.out, '0);
`else
      check("relu_all", bus.out, {M{32'hEC00_0000}});
`endif
      release_out("relu");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
